// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer for the unified Memory port: serialises CPU and DMA accesses,
// blocks illegal ones without a bus cycle, captures read data and returns a one-cycle ack.
module mem_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter logic [31:0] DISP_LIMIT = 32'd9600,
  parameter logic [31:0] RAM_BASE   = 32'd140672,
  parameter logic [31:0] KEY_ADDR   = 32'd206204
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_isWrite,
  input  logic        m0_byteWrite,
  input  logic        m0_byteRead,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_writeData,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_readData,
  input  logic        m1_req,
  input  logic        m1_isWrite,
  input  logic        m1_byteWrite,
  input  logic        m1_byteRead,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_writeData,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_readData,
  output logic        mem_isWrite,
  output logic        mem_byteWrite,
  output logic        mem_byteRead,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  input  logic [31:0] mem_RD,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CAP, S_REJ, S_DONE} state_t;

  state_t      state_q;
  logic        gnt_q;
  logic        last_q;
  logic        gnt_d;
  logic        illegal_d;
  logic        sel_w, sel_bw, sel_br;
  logic [31:0] sel_addr, sel_wd;

  always_comb begin
    gnt_d = 1'b0;
    if (m0_req && m1_req) gnt_d = FIXED_PRIO ? 1'b0 : ~last_q;
    else                  gnt_d = m1_req;
    sel_w    = gnt_d ? m1_isWrite   : m0_isWrite;
    sel_bw   = gnt_d ? m1_byteWrite : m0_byteWrite;
    sel_br   = gnt_d ? m1_byteRead  : m0_byteRead;
    sel_addr = gnt_d ? m1_address   : m0_address;
    sel_wd   = gnt_d ? m1_writeData : m0_writeData;
    // ROM is read-only; the DMA engine must not consume keyboard reads (read side effect)
    illegal_d = (sel_w && (sel_addr >= DISP_LIMIT) && (sel_addr < RAM_BASE)) ||
                (gnt_d && !sel_w && (sel_addr == KEY_ADDR));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      gnt_q         <= 1'b0;
      last_q        <= 1'b1;
      busy          <= 1'b0;
      mem_isWrite   <= 1'b0;
      mem_byteWrite <= 1'b0;
      mem_byteRead  <= 1'b0;
      mem_address   <= 32'd0;
      mem_writeData <= 32'd0;
      m0_ack        <= 1'b0;
      m0_err        <= 1'b0;
      m0_readData   <= 32'd0;
      m1_ack        <= 1'b0;
      m1_err        <= 1'b0;
      m1_readData   <= 32'd0;
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q  <= gnt_d;
            last_q <= gnt_d;
            busy   <= 1'b1;
            if (illegal_d) begin
              state_q <= S_REJ;
            end else begin
              mem_isWrite   <= sel_w;
              mem_byteWrite <= sel_bw;
              mem_byteRead  <= sel_br;
              mem_address   <= sel_addr;
              mem_writeData <= sel_wd;
              state_q       <= sel_w ? S_WR : S_RD;
            end
          end
        end
        S_WR: begin
          mem_isWrite <= 1'b0;
          if (gnt_q) m1_ack <= 1'b1;
          else       m0_ack <= 1'b1;
          state_q <= S_DONE;
        end
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          // address stays put here: Memory's byte-lane latch and keyboard path key off it
          if (gnt_q) begin
            m1_readData <= mem_RD;
            m1_ack      <= 1'b1;
          end else begin
            m0_readData <= mem_RD;
            m0_ack      <= 1'b1;
          end
          state_q <= S_DONE;
        end
        S_REJ: begin
          if (gnt_q) begin
            m1_ack <= 1'b1;
            m1_err <= 1'b1;
          end else begin
            m0_ack <= 1'b1;
            m0_err <= 1'b1;
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 round-robin, instance 1 fixed priority, each with a
// behavioural synchronous Memory; expected acks queued at issue and checked on completion.
module tb_mem_arbiter;

  localparam logic [31:0] RAM_BASE = 32'd140672;
  localparam logic [31:0] KEY_ADDR = 32'd206204;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        req  [2][2];
  logic        isw  [2][2];
  logic        bw   [2][2];
  logic        br   [2][2];
  logic [31:0] addr [2][2];
  logic [31:0] wd   [2][2];
  logic        ack  [2][2];
  logic        err  [2][2];
  logic [31:0] rdat [2][2];
  logic        m_isw  [2];
  logic        m_bw   [2];
  logic        m_br   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  logic        busy   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] rd_q = 32'd0;
    logic [31:0] mem [int];

    mem_arbiter #(.FIXED_PRIO(g == 1)) u_dut (
      .clock(clock), .reset(reset),
      .m0_req(req[g][0]), .m0_isWrite(isw[g][0]), .m0_byteWrite(bw[g][0]),
      .m0_byteRead(br[g][0]), .m0_address(addr[g][0]), .m0_writeData(wd[g][0]),
      .m0_ack(ack[g][0]), .m0_err(err[g][0]), .m0_readData(rdat[g][0]),
      .m1_req(req[g][1]), .m1_isWrite(isw[g][1]), .m1_byteWrite(bw[g][1]),
      .m1_byteRead(br[g][1]), .m1_address(addr[g][1]), .m1_writeData(wd[g][1]),
      .m1_ack(ack[g][1]), .m1_err(err[g][1]), .m1_readData(rdat[g][1]),
      .mem_isWrite(m_isw[g]), .mem_byteWrite(m_bw[g]), .mem_byteRead(m_br[g]),
      .mem_address(m_addr[g]), .mem_writeData(m_wd[g]), .mem_RD(rd_q), .busy(busy[g])
    );

    // Memory model: word array, byte lanes by address[1:0], read data one cycle later
    always @(posedge clock) begin
      logic [31:0] w;
      int          idx;
      int          lane;
      idx  = int'(m_addr[g] >> 2);
      lane = int'(m_addr[g][1:0]);
      w    = mem.exists(idx) ? mem[idx] : 32'd0;
      if (m_isw[g]) begin
        if (m_bw[g]) w[lane*8 +: 8] = m_wd[g][7:0];
        else         w = m_wd[g];
        mem[idx] = w;
      end
      rd_q <= m_br[g] ? {24'd0, w[lane*8 +: 8]} : w;
    end
  end

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t sbq [4][$];

  task automatic drive(input int d, input int m, input logic w, input logic b_w, input logic b_r,
                       input logic [31:0] a, input logic [31:0] dat,
                       input logic e_err, input logic e_chk, input logic [31:0] e_dat);
    exp_t e;
    isw[d][m]  = w;
    bw[d][m]   = b_w;
    br[d][m]   = b_r;
    addr[d][m] = a;
    wd[d][m]   = dat;
    req[d][m]  = 1'b1;
    e.err  = e_err;
    e.chk  = e_chk;
    e.data = e_dat;
    sbq[d*2+m].push_back(e);
  endtask

  // Waits for the master's ack, scoring it against the queue; reports latency and write pulses.
  task automatic wait_ack(input int d, input int m, output int lat, output int wp, output int wo);
    int   start;
    exp_t e;
    start = cyc;
    lat   = -1;
    wp    = 0;
    wo    = -1;
    for (int i = 0; i < 30 && lat < 0; i++) begin
      @(negedge clock);
      if (m_isw[d]) begin
        wp++;
        wo = cyc - start;
      end
      if (ack[d][m]) begin
        lat = cyc - start;
        tests_run++;
        if (sbq[d*2+m].size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_ack d%0d m%0d", d, m);
        end else begin
          e = sbq[d*2+m].pop_front();
          if (err[d][m] !== e.err || (e.chk && rdat[d][m] !== e.data)) begin
            tests_failed++;
            $display("FAIL sb_d%0d_m%0d got err=%0b data=%h, want err=%0b data=%h",
                     d, m, err[d][m], rdat[d][m], e.err, e.data);
          end
        end
      end
    end
    if (lat < 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ack_timeout d%0d m%0d got no ack, want ack within 30 cycles", d, m);
    end
    @(posedge clock);
    #1 req[d][m] = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) req[d][m] = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if ({busy[d], m_isw[d], m_bw[d], m_br[d], ack[d][0], ack[d][1], err[d][0], err[d][1]} !== 8'd0 ||
          m_addr[d] !== 32'd0 || m_wd[d] !== 32'd0 || rdat[d][0] !== 32'd0 || rdat[d][1] !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_state d%0d got busy=%0b isw=%0b addr=%h rd0=%h rd1=%h, want all 0",
                 d, busy[d], m_isw[d], m_addr[d], rdat[d][0], rdat[d][1]);
      end
    end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, wp, wo;
    @(posedge clock); #1;
    drive(0, 0, 1'b1, 1'b0, 1'b0, RAM_BASE, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    wait_ack(0, 0, lat, wp, wo);
    tests_run++;
    if (lat !== 2 || wp !== 1 || wo !== 1) begin
      tests_failed++;
      $display("FAIL write_timing got lat=%0d pulses=%0d at=%0d, want 2/1/1", lat, wp, wo);
    end
    @(posedge clock); #1;
    drive(0, 0, 1'b0, 1'b0, 1'b0, RAM_BASE, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    wait_ack(0, 0, lat, wp, wo);
    tests_run++;
    if (lat !== 3 || wp !== 0) begin
      tests_failed++;
      $display("FAIL read_timing got lat=%0d pulses=%0d, want 3/0", lat, wp);
    end
  endtask

  task automatic test_arbitration(input int d);
    int   order[$];
    int   sent[2];
    int   got;
    logic bad;
    exp_t e;
    apply_reset();
    @(posedge clock); #1;
    drive(d, 0, 1'b1, 1'b0, 1'b0, RAM_BASE + 32'h100, 32'hA0, 1'b0, 1'b0, 32'd0);
    drive(d, 1, 1'b0, 1'b0, 1'b0, RAM_BASE + 32'h200, 32'd0, 1'b0, 1'b1, 32'd0);
    sent[0] = 1;
    sent[1] = 1;
    for (int i = 0; i < 80 && order.size() < 8; i++) begin
      @(negedge clock);
      got = -1;
      for (int m = 0; m < 2; m++) begin
        if (ack[d][m]) begin
          got = m;
          order.push_back(m);
          e = sbq[d*2+m].pop_front();
          tests_run++;
          if (err[d][m] !== e.err || (e.chk && rdat[d][m] !== e.data)) begin
            tests_failed++;
            $display("FAIL arb_sb_d%0d_m%0d got err=%0b data=%h, want err=%0b data=%h",
                     d, m, err[d][m], rdat[d][m], e.err, e.data);
          end
        end
      end
      @(posedge clock); #1;
      if (got == 0 && sent[0] < 4) begin
        drive(d, 0, 1'b1, 1'b0, 1'b0, RAM_BASE + 32'h100 + 32'(4*sent[0]), 32'hA0 + 32'(sent[0]),
              1'b0, 1'b0, 32'd0);
        sent[0]++;
      end else if (got == 1 && sent[1] < 4) begin
        drive(d, 1, 1'b0, 1'b0, 1'b0, RAM_BASE + 32'h200 + 32'(4*sent[1]), 32'd0, 1'b0, 1'b1, 32'd0);
        sent[1]++;
      end else if (got >= 0) begin
        req[d][got] = 1'b0;
      end
    end
    bad = (order.size() != 8);
    for (int i = 0; i < order.size(); i++)
      if (order[i] != ((d == 1) ? ((i < 4) ? 0 : 1) : (i % 2))) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL grant_order_d%0d got %p, want %s", d, order,
               (d == 1) ? "0,0,0,0,1,1,1,1" : "0,1,0,1,0,1,0,1");
    end
  endtask

  task automatic test_illegal();
    int          lat, wp, wo;
    logic [31:0] a0;
    a0 = m_addr[0];
    @(posedge clock); #1;
    drive(0, 1, 1'b1, 1'b0, 1'b0, 32'd20000, 32'h1111_2222, 1'b1, 1'b0, 32'd0);
    wait_ack(0, 1, lat, wp, wo);
    tests_run++;
    if (lat !== 2 || wp !== 0 || m_addr[0] !== a0) begin
      tests_failed++;
      $display("FAIL rom_write got lat=%0d pulses=%0d addr=%h, want 2/0/%h", lat, wp, m_addr[0], a0);
    end
    @(posedge clock); #1;
    drive(0, 1, 1'b0, 1'b0, 1'b0, KEY_ADDR, 32'd0, 1'b1, 1'b0, 32'd0);
    wait_ack(0, 1, lat, wp, wo);
    tests_run++;
    if (lat !== 2 || m_addr[0] !== a0) begin
      tests_failed++;
      $display("FAIL m1_key_read got lat=%0d addr=%h, want 2/%h", lat, m_addr[0], a0);
    end
    @(posedge clock); #1;
    drive(0, 0, 1'b0, 1'b0, 1'b0, KEY_ADDR, 32'd0, 1'b0, 1'b0, 32'd0);
    wait_ack(0, 0, lat, wp, wo);
    tests_run++;
    if (lat !== 3 || m_addr[0] !== KEY_ADDR) begin
      tests_failed++;
      $display("FAIL m0_key_read got lat=%0d addr=%h, want 3/%h", lat, m_addr[0], KEY_ADDR);
    end
  endtask

  task automatic test_byte();
    int lat, wp, wo;
    @(posedge clock); #1;
    drive(0, 0, 1'b1, 1'b1, 1'b0, RAM_BASE + 32'd1, 32'h0000_005A, 1'b0, 1'b0, 32'd0);
    wait_ack(0, 0, lat, wp, wo);
    tests_run++;
    if (lat !== 2 || wp !== 1) begin
      tests_failed++;
      $display("FAIL byte_write got lat=%0d pulses=%0d, want 2/1", lat, wp);
    end
    @(posedge clock); #1;
    drive(0, 0, 1'b0, 1'b0, 1'b1, RAM_BASE + 32'd1, 32'd0, 1'b0, 1'b1, 32'h0000_005A);
    @(negedge clock);
    @(negedge clock);
    tests_run++;
    if (m_addr[0] !== RAM_BASE + 32'd1 || m_br[0] !== 1'b1 || m_isw[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL byte_rd_addr got addr=%h br=%0b isw=%0b, want %h/1/0",
               m_addr[0], m_br[0], m_isw[0], RAM_BASE + 32'd1);
    end
    @(negedge clock);
    tests_run++;
    if (m_addr[0] !== RAM_BASE + 32'd1) begin
      tests_failed++;
      $display("FAIL byte_cap_addr got addr=%h, want %h", m_addr[0], RAM_BASE + 32'd1);
    end
    wait_ack(0, 0, lat, wp, wo);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("FAIL byte_read_ack got %0d cycles after CAP, want 1", lat);
    end
  endtask

  task automatic test_reset_mid();
    int   lat, wp, wo;
    logic seen;
    @(posedge clock); #1;
    drive(0, 1, 1'b0, 1'b0, 1'b0, RAM_BASE, 32'd0, 1'b0, 1'b1, 32'hDEAD5AEF);
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset     = 1'b0;
    req[0][1] = 1'b0;
    sbq[1].delete();
    @(negedge clock);
    tests_run++;
    if ({busy[0], m_isw[0], m_bw[0], m_br[0], ack[0][1]} !== 5'd0 || m_addr[0] !== 32'd0 ||
        m_wd[0] !== 32'd0 || rdat[0][1] !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_reset got busy=%0b isw=%0b br=%0b addr=%h ack1=%0b, want all 0",
               busy[0], m_isw[0], m_br[0], m_addr[0], ack[0][1]);
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (ack[0][1]) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL aborted_ack got ack=1, want no ack");
    end
    @(posedge clock); #1;
    drive(0, 1, 1'b0, 1'b0, 1'b0, RAM_BASE, 32'd0, 1'b0, 1'b1, 32'hDEAD5AEF);
    wait_ack(0, 1, lat, wp, wo);
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("FAIL reissue_read got lat=%0d, want 3", lat);
    end
  endtask

  task automatic test_back_to_back();
    int   k, a0, a1, nbusy;
    exp_t e;
    @(posedge clock); #1;
    drive(0, 0, 1'b1, 1'b0, 1'b0, 32'd100, 32'h0000_1234, 1'b0, 1'b0, 32'd0);
    k     = cyc;
    a0    = -1;
    a1    = -1;
    nbusy = 0;
    for (int i = 0; i < 20 && a1 < 0; i++) begin
      @(negedge clock);
      if (busy[0] && (cyc - k) inside {1, 2, 4, 5, 6}) nbusy++;
      for (int m = 0; m < 2; m++) begin
        if (ack[0][m]) begin
          if (m == 0) a0 = cyc - k;
          else        a1 = cyc - k;
          e = sbq[m].pop_front();
          tests_run++;
          if (err[0][m] !== e.err || (e.chk && rdat[0][m] !== e.data)) begin
            tests_failed++;
            $display("FAIL b2b_sb_m%0d got err=%0b data=%h, want err=%0b data=%h",
                     m, err[0][m], rdat[0][m], e.err, e.data);
          end
        end
      end
      @(posedge clock); #1;
      if (cyc == k + 1) drive(0, 1, 1'b0, 1'b0, 1'b0, 32'd100, 32'd0, 1'b0, 1'b1, 32'h0000_1234);
      if (a0 >= 0) req[0][0] = 1'b0;
      if (a1 >= 0) req[0][1] = 1'b0;
    end
    tests_run++;
    if (a0 !== 2 || a1 !== 6 || nbusy !== 5) begin
      tests_failed++;
      $display("FAIL back_to_back got ack0@%0d ack1@%0d busy_cycles=%0d, want 2/6/5", a0, a1, nbusy);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) begin
        req[d][m]  = 1'b0;
        isw[d][m]  = 1'b0;
        bw[d][m]   = 1'b0;
        br[d][m]   = 1'b0;
        addr[d][m] = 32'd0;
        wd[d][m]   = 32'd0;
      end
    test_reset();
    test_write_read();
    test_illegal();
    test_byte();
    test_reset_mid();
    test_back_to_back();
    test_arbitration(0);
    test_arbitration(1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion, want finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
